uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx.sv | 98 +++++++++
 tb/tb_uart_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and the future receiver.
package uart_pkg;

  typedef enum logic {
    IDLE,
    TRANSMIT
  } uart_state_e;

  localparam int unsigned FRAME_BITS = 10;
  // 50 MHz system clock at 19200 baud
  localparam int unsigned BAUD_DIV_DEFAULT = 2604;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: pulses shift_o on the last clock of each bit while enabled.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic shift_o
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign shift_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [3:0] LastBit = 4'(FRAME_BITS - 1);

  uart_state_e state_q, state_d;
  logic [FRAME_BITS-1:0] shift_reg_q, shift_reg_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  busy_q, busy_d;
  logic                  tx_done_q, tx_done_d;
  logic                  accept;
  logic                  frame_end;
  logic                  baud_shift;

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (state_q == TRANSMIT),
    .shift_o(baud_shift)
  );

  assign accept    = (state_q == IDLE) && trmt;
  assign frame_end = (state_q == TRANSMIT) && baud_shift && (bit_cnt_q == LastBit);

  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    bit_cnt_d   = bit_cnt_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (trmt) begin
          shift_reg_d = {1'b1, tx_data, 1'b0};
          bit_cnt_d   = '0;
          busy_d      = 1'b1;
          state_d     = TRANSMIT;
        end
      end
      TRANSMIT: begin
        if (baud_shift) begin
          // Filling with ones leaves the line idle high once the stop bit is shifted out
          shift_reg_d = {1'b1, shift_reg_q[FRAME_BITS-1:1]};
          bit_cnt_d   = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LastBit) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Set wins over clear
  always_comb begin
    tx_done_d = tx_done_q;
    if (frame_end) begin
      tx_done_d = 1'b1;
    end else if (accept) begin
      tx_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_reg_q <= '1;
      bit_cnt_q   <= '0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign TX      = shift_reg_q[0];
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at BAUD_DIV=4 and BAUD_DIV=2 against a bit-period frame model.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4_n, trmt4, tx4, busy4, done4;
  logic       rst2_n, trmt2, tx2, busy2, done2;
  logic [7:0] data4, data2;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.BAUD_DIV(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst4_n),
    .trmt   (trmt4),
    .tx_data(data4),
    .TX     (tx4),
    .busy   (busy4),
    .tx_done(done4)
  );

  uart_tx #(.BAUD_DIV(2)) dut2 (
    .clk    (clk),
    .rst_n  (rst2_n),
    .trmt   (trmt2),
    .tx_data(data2),
    .TX     (tx2),
    .busy   (busy2),
    .tx_done(done2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic t, input logic [7:0] d);
    if (sel) begin
      trmt2 = t;
      data2 = d;
    end else begin
      trmt4 = t;
      data4 = d;
    end
  endtask

  task automatic check_outs(input bit sel, input string tag, input logic e_tx, input logic e_busy,
                            input logic e_done);
    chk($sformatf("%s.TX", tag), sel ? tx2 : tx4, e_tx);
    chk($sformatf("%s.busy", tag), sel ? busy2 : busy4, e_busy);
    chk($sformatf("%s.tx_done", tag), sel ? done2 : done4, e_done);
  endtask

  // Caller raises trmt at a negedge; this follows the frame cycle by cycle through the
  // first idle cycle. mode 1: extra trmt of 0x3C at cycles 10 and 20. mode 2: toggle tx_data.
  task automatic expect_frame(input bit sel, input logic [7:0] d, input int mode, input string tag);
    int b = sel ? 2 : 4;
    logic [9:0] frame = {1'b1, d, 1'b0};
    logic [7:0] cur = d;
    for (int k = 1; k <= 10 * b + 1; k++) begin
      @(negedge clk);
      drive(sel, 1'b0, cur);
      if (k <= 10 * b) begin
        check_outs(sel, $sformatf("%s[c%0d]", tag, k), frame[(k - 1) / b], 1'b1, 1'b0);
      end else begin
        check_outs(sel, $sformatf("%s[end]", tag), 1'b1, 1'b0, 1'b1);
      end
      if (k <= 10 * b) begin
        if (mode == 1 && (k == 10 || k == 20)) begin
          cur = 8'h3C;
          drive(sel, 1'b1, cur);
        end else if (mode == 2) begin
          cur = ~cur;
          drive(sel, 1'b0, cur);
        end
      end
    end
  endtask

  task automatic expect_idle(input bit sel, input int n, input logic e_done, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outs(sel, $sformatf("%s[i%0d]", tag, i), 1'b1, 1'b0, e_done);
    end
  endtask

  initial begin
    rst4_n = 1'b0;
    rst2_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check_outs(1'b0, "reset4", 1'b1, 1'b0, 1'b0);
    check_outs(1'b1, "reset2", 1'b1, 1'b0, 1'b0);
    rst4_n = 1'b1;
    rst2_n = 1'b1;
    expect_idle(1'b0, 4, 1'b0, "post_reset");

    // 0xA5 basic frame
    drive(1'b0, 1'b1, 8'hA5);
    expect_frame(1'b0, 8'hA5, 0, "a5");
    expect_idle(1'b0, 3, 1'b1, "a5_idle");

    // Back-to-back: new trmt in the first idle cycle
    drive(1'b0, 1'b1, 8'h00);
    expect_frame(1'b0, 8'h00, 0, "b2b_00");
    drive(1'b0, 1'b1, 8'hFF);
    expect_frame(1'b0, 8'hFF, 0, "b2b_ff");
    expect_idle(1'b0, 2, 1'b1, "b2b_idle");

    // trmt during a frame is ignored
    drive(1'b0, 1'b1, 8'h81);
    expect_frame(1'b0, 8'h81, 1, "ignore");
    expect_idle(1'b0, 50, 1'b1, "no_second");

    // tx_data changes after acceptance have no effect
    drive(1'b0, 1'b1, 8'h5A);
    expect_frame(1'b0, 8'h5A, 2, "toggle");
    expect_idle(1'b0, 2, 1'b1, "toggle_idle");

    // Random bytes with random gaps (gap 0 = back-to-back)
    for (int n = 0; n < 6; n++) begin
      logic [7:0] d;
      int gap;
      d   = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      drive(1'b0, 1'b1, d);
      expect_frame(1'b0, d, 0, $sformatf("rnd%0d_%02h", n, d));
      expect_idle(1'b0, gap, 1'b1, $sformatf("rnd%0d_gap", n));
    end

    // Reset at cycle 17 of a 0xC3 frame (data bit 3 = 0 on the line then)
    drive(1'b0, 1'b1, 8'hC3);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 8'hC3);
    end
    chk("mid_reset.pre_TX", tx4, 1'b0);
    chk("mid_reset.pre_busy", busy4, 1'b1);
    rst4_n = 1'b0;
    #1;
    check_outs(1'b0, "mid_reset", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst4_n = 1'b1;
    expect_idle(1'b0, 45, 1'b0, "after_reset");

    // BAUD_DIV=2 boundary
    drive(1'b1, 1'b1, 8'h01);
    expect_frame(1'b1, 8'h01, 0, "div2");
    expect_idle(1'b1, 3, 1'b1, "div2_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
